// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP gray-image path.
// Frame geometry, pixel/address widths and the image-server state encoding.
package lbp_pkg;

  localparam int IMG_DIM = 128;
  localparam int ADDR_W  = 2 * $clog2(IMG_DIM);
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 16;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_DIM * IMG_DIM - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/gray_pix_ram.sv
// Frame pixel store: synchronous write, asynchronous read.
// Sized exactly 2^AW entries so any read address is in range.
module gray_pix_ram
  import lbp_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          wclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset; clearing 16K entries is never needed since a frame is always fully rewritten before it is served.
  always_ff @(posedge wclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gray_image_server.sv
// Responder for the LBP gray-image read interface: loads one 128x128 frame
// over a valid/ready stream, then serves combinational reads until frame_done.
module gray_image_server
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_err,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              frame_done,
  output logic [CNT_W-1:0]  req_count
);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  assign wr_en = load_valid && load_ready;

  gray_pix_ram u_ram (
    .wclk  (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (gray_addr),
    .rdata (rd_data)
  );

  // Reads outside SERVE return zero so a stale frame never leaks out.
  assign gray_data = (state == SERVE && gray_req) ? rd_data : '0;

  // NOTE: all state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      load_ready <= 1'b1;
      load_err   <= 1'b0;
      gray_ready <= 1'b0;
      req_count  <= '0;
    end else begin
      load_err <= 1'b0;
      unique case (state)
        LOAD: begin
          if (wr_en) begin
            if (wr_ptr == LAST_PIX) begin
              // A missing load_last is flagged but the full frame is kept.
              state      <= SERVE;
              wr_ptr     <= '0;
              load_ready <= 1'b0;
              gray_ready <= 1'b1;
              load_err   <= !load_last;
            end else if (load_last) begin
              load_err <= 1'b1;
              wr_ptr   <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        SERVE: begin
          if (gray_req && req_count != CNT_MAX) req_count <= req_count + 1'b1;
          if (frame_done) begin
            state      <= DRAIN;
            gray_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // Count stays visible for this one cycle after frame_done.
          state      <= LOAD;
          load_ready <= 1'b1;
          req_count  <= '0;
        end
        default: begin
          state      <= LOAD;
          load_ready <= 1'b1;
          gray_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_image_server.sv
// Directed bench for gray_image_server: frame loads, framing errors,
// neighbourhood reads, frame_done handshake and reset behaviour.
module tb_gray_image_server;
  import lbp_pkg::*;

  localparam int PIX = IMG_DIM * IMG_DIM;
  localparam int LOAD_LIMIT = 40000;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_err;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic              frame_done;
  logic [CNT_W-1:0]  req_count;

  logic [DATA_W-1:0] model [PIX];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rd_vec_t;

  rd_vec_t vecs [9];

  always #5 clk = ~clk;

  gray_image_server dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_err   (load_err),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .frame_done (frame_done),
    .req_count  (req_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix(input int kind, input int beat);
    logic [31:0] b;
    b = beat;
    case (kind)
      0:       return b[7:0];
      1:       return 8'(beat * 7 + 3);
      default: return 8'($urandom);
    endcase
  endfunction

  // Streams one full frame; duty is the percent chance of load_valid per cycle.
  task automatic load_frame(input int kind, input int duty, input bit with_last, input bit fd_on_last);
    int beat = 0;
    int cyc = 0;
    int err_seen = 0;
    int ready_low = 0;
    bit go;
    logic [DATA_W-1:0] d;
    while (beat < PIX && cyc < LOAD_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (load_err) err_seen++;
      if (!load_ready) ready_low++;
      go = ($urandom_range(0, 99) < duty);
      load_valid = go;
      frame_done = 1'b0;
      if (go) begin
        d = pix(kind, beat);
        load_data = d;
        load_last = with_last && (beat == PIX - 1);
        frame_done = fd_on_last && (beat == PIX - 1);
        if (load_ready) begin
          model[beat] = d;
          beat++;
        end
      end
    end
    check("load_beats_accepted", beat, PIX);
    check("load_ready_during_load", ready_low, 0);
    check("load_err_during_load", err_seen, 0);
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    frame_done = 1'b0;
    check("gray_ready_after_last", gray_ready, 1);
    check("load_ready_in_serve", load_ready, 0);
    check("load_err_at_frame_end", load_err, with_last ? 0 : 1);
  endtask

  task automatic read_check(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    @(negedge clk);
    gray_addr = a;
    gray_req  = 1'b1;
    #2;
    check(name, gray_data, exp);
  endtask

  task automatic verify_reads(input int n);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = ADDR_W'($urandom_range(0, PIX - 1));
      read_check("random_read", a, model[a]);
    end
    @(negedge clk);
    gray_req = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge clk);
    gray_req   = 1'b0;
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // 3x3 around {row 5, col 5} of the ramp frame: data = low byte of row*128+col.
    vecs[0] = '{{7'd4, 7'd4}, 8'h04};
    vecs[1] = '{{7'd4, 7'd5}, 8'h05};
    vecs[2] = '{{7'd4, 7'd6}, 8'h06};
    vecs[3] = '{{7'd5, 7'd4}, 8'h84};
    vecs[4] = '{{7'd5, 7'd5}, 8'h85};
    vecs[5] = '{{7'd5, 7'd6}, 8'h86};
    vecs[6] = '{{7'd6, 7'd4}, 8'h04};
    vecs[7] = '{{7'd6, 7'd5}, 8'h05};
    vecs[8] = '{{7'd6, 7'd6}, 8'h06};

    reset = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    gray_req   = 1'b0;
    gray_addr  = '0;
    frame_done = 1'b0;

    @(negedge clk);
    check("rst_load_ready", load_ready, 1);
    check("rst_gray_ready", gray_ready, 0);
    check("rst_load_err", load_err, 0);
    check("rst_req_count", req_count, 0);
    check("rst_gray_data", gray_data, 0);
    reset = 1'b0;

    // frame_done in LOAD is ignored.
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    check("fd_in_load_ready", load_ready, 1);
    check("fd_in_load_gray", gray_ready, 0);

    // Ramp frame, then neighbourhood reads from the table.
    load_frame(0, 100, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) read_check("nbhd_read", vecs[i].addr, vecs[i].data);
    @(negedge clk);
    gray_req = 1'b0;
    #2;
    check("data_zero_req_low", gray_data, 0);
    check("req_count_nbhd", req_count, 9);
    read_check("ramp_0305", 14'h0305, 8'h05);

    // frame_done handshake: count held through DRAIN, then cleared.
    @(negedge clk);
    gray_req   = 1'b0;
    frame_done = 1'b1;
    #2;
    check("fd_pre_gray_ready", gray_ready, 1);
    check("fd_pre_count", req_count, 10);
    @(negedge clk);
    frame_done = 1'b0;
    check("drain_gray_ready", gray_ready, 0);
    check("drain_load_ready", load_ready, 0);
    check("drain_count_held", req_count, 10);
    @(negedge clk);
    check("post_drain_load_ready", load_ready, 1);
    check("post_drain_count", req_count, 0);
    read_check("read_in_load", 14'h0305, 8'h00);
    @(negedge clk);
    gray_req = 1'b0;
    check("no_count_in_load", req_count, 0);

    // Early load_last on beat 100.
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 8'hA5 ^ 8'(i);
      load_last  = (i == 100);
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("early_last_err", load_err, 1);
    check("early_last_gray_ready", gray_ready, 0);
    @(negedge clk);
    check("early_last_err_pulse", load_err, 0);
    check("early_last_still_load", load_ready, 1);

    // Full frame after the discarded one; frame_done coincides with the SERVE entry edge.
    load_frame(1, 100, 1'b1, 1'b1);
    @(negedge clk);
    check("fd_at_entry_ignored", gray_ready, 1);
    read_check("new_frame_pix0", '0, 8'h03);
    verify_reads(16);
    end_frame();

    // Reset after 5000 accepted beats.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 8'hEE;
    end
    @(negedge clk);
    load_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("mid_load_rst_gray_ready", gray_ready, 0);
    check("mid_load_rst_load_ready", load_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Backpressured random frame without load_last: error flagged, frame kept.
    load_frame(2, 70, 1'b0, 1'b0);
    read_check("bp_pix0", '0, model[0]);
    read_check("bp_last", ADDR_W'(PIX - 1), model[PIX - 1]);
    verify_reads(64);

    // Reset mid-serve drops gray_ready without a clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_serve_rst_gray_ready", gray_ready, 0);
    check("mid_serve_rst_count", req_count, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
